// File: rtl/cu_bubble_pipe.sv
// Control-bundle pipeline register between the control unit and EX, with
// stall, flush and multi-cycle bubble injection plus a saturating bubble count.
module cu_bubble_pipe #(
  parameter int unsigned       CTRL_W     = 9,
  parameter logic [CTRL_W-1:0] SAFE_VALUE = '0,
  parameter int unsigned       BCNT_W     = 2,
  parameter int unsigned       STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble_req,
  input  logic [BCNT_W-1:0] bubble_len,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              hold_upstream,
  output logic              bubble_active,
  output logic [STAT_W-1:0] bubble_total
);

  typedef enum logic {
    IDLE,
    BUBBLE
  } state_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] rem_q, rem_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [STAT_W-1:0] total_q, total_d;
  logic [STAT_W-1:0] total_inc;
  logic              start_bubble;

  assign start_bubble = (state_q == IDLE) && bubble_req && (bubble_len != '0);
  assign total_inc    = (&total_q) ? total_q : total_q + STAT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ctrl_q  <= SAFE_VALUE;
      valid_q <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      total_q <= total_d;
    end
  end

  // Priority: flush > stall > bubble sequencing > pass-through.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    total_d = total_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      ctrl_d  = SAFE_VALUE;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (state_q == BUBBLE) begin
        ctrl_d  = SAFE_VALUE;
        valid_d = 1'b0;
        total_d = total_inc;
        rem_d   = rem_q - BCNT_W'(1);
        state_d = (rem_q == BCNT_W'(1)) ? IDLE : BUBBLE;
      end else if (start_bubble) begin
        ctrl_d  = SAFE_VALUE;
        valid_d = 1'b0;
        total_d = total_inc;
        rem_d   = bubble_len - BCNT_W'(1);
        state_d = (bubble_len > BCNT_W'(1)) ? BUBBLE : IDLE;
      end else begin
        ctrl_d  = valid_in ? ctrl_in : SAFE_VALUE;
        valid_d = valid_in;
      end
    end
  end

  always_comb begin
    ctrl_out      = ctrl_q;
    valid_out     = valid_q;
    bubble_total  = total_q;
    bubble_active = (state_q == BUBBLE);
    hold_upstream = !flush && ((state_q == BUBBLE) || (start_bubble && !stall));
  end

endmodule
